// File: rtl/nexys_starship_lives_if.sv
// rtl/nexys_starship_lives_if.sv - game-side signal bundle for the lives/score keeper
interface nexys_starship_lives_if #(
  parameter int LIVES_W = 2,
  parameter int SCORE_W = 14
);
  logic               q_Play;
  logic               hit;
  logic               kill;
  logic               tick;
  logic [LIVES_W-1:0] lives;
  logic [SCORE_W-1:0] score;
  logic               invincible;
  logic               gameover_ctrl;

  modport master (
    output q_Play, hit, kill, tick,
    input  lives, score, invincible, gameover_ctrl
  );

  modport slave (
    input  q_Play, hit, kill, tick,
    output lives, score, invincible, gameover_ctrl
  );
endinterface

// File: rtl/nexys_starship_lives.sv
// rtl/nexys_starship_lives.sv - lives, invulnerability window and saturating score; drives gameover_ctrl
module nexys_starship_lives #(
  parameter int START_LIVES  = 3,
  parameter int LIVES_W      = 2,
  parameter int INVULN_TICKS = 120,
  parameter int INV_W        = 7,
  parameter int SCORE_W      = 14,
  parameter int SCORE_MAX    = 9999,
  parameter int KILL_POINTS  = 1
) (
  input logic Clk,
  input logic Reset,
  nexys_starship_lives_if.slave bus
);

  typedef enum logic [3:0] {
    IDLE   = 4'b0001,
    ALIVE  = 4'b0010,
    INVULN = 4'b0100,
    DEAD   = 4'b1000
  } state_t;

  state_t             state, state_n;
  logic [LIVES_W-1:0] lives_q, lives_n;
  logic [SCORE_W-1:0] score_q, score_n;
  logic [INV_W-1:0]   inv_cnt, inv_cnt_n;
  logic               invincible_q, invincible_n;
  logic               gameover_q, gameover_n;

  // One bit of headroom so the saturation compare sees the true sum.
  logic [SCORE_W:0]   score_sum;
  logic [SCORE_W-1:0] score_kill;

  always_comb begin
    score_sum  = {1'b0, score_q} + (SCORE_W+1)'(KILL_POINTS);
    score_kill = (score_sum > (SCORE_W+1)'(SCORE_MAX)) ? SCORE_W'(SCORE_MAX)
                                                       : score_sum[SCORE_W-1:0];
  end

  always_ff @(posedge Clk) begin
    if (!Reset) begin
      state        <= IDLE;
      lives_q      <= LIVES_W'(START_LIVES);
      score_q      <= '0;
      inv_cnt      <= '0;
      invincible_q <= 1'b0;
      gameover_q   <= 1'b0;
    end else begin
      state        <= state_n;
      lives_q      <= lives_n;
      score_q      <= score_n;
      inv_cnt      <= inv_cnt_n;
      invincible_q <= invincible_n;
      gameover_q   <= gameover_n;
    end
  end

  always_comb begin
    state_n      = state;
    lives_n      = lives_q;
    score_n      = score_q;
    inv_cnt_n    = inv_cnt;
    invincible_n = invincible_q;
    gameover_n   = gameover_q;

    case (state)
      IDLE: begin
        if (bus.q_Play) begin
          state_n = ALIVE;
          lives_n = LIVES_W'(START_LIVES);
          score_n = '0;
        end
      end

      ALIVE: begin
        if (!bus.q_Play) begin
          state_n      = IDLE;
          invincible_n = 1'b0;
          inv_cnt_n    = '0;
        end else begin
          if (bus.kill)
            score_n = score_kill;
          if (bus.hit) begin
            if (lives_q == LIVES_W'(1)) begin
              state_n    = DEAD;
              lives_n    = '0;
              gameover_n = 1'b1;
            end else begin
              state_n      = INVULN;
              lives_n      = lives_q - LIVES_W'(1);
              inv_cnt_n    = INV_W'(INVULN_TICKS);
              invincible_n = 1'b1;
            end
          end
        end
      end

      INVULN: begin
        if (!bus.q_Play) begin
          state_n      = IDLE;
          invincible_n = 1'b0;
          inv_cnt_n    = '0;
        end else begin
          if (bus.kill)
            score_n = score_kill;
          // Hits are swallowed for the whole window, including the expiring tick.
          if (bus.tick) begin
            if (inv_cnt <= INV_W'(1)) begin
              state_n      = ALIVE;
              inv_cnt_n    = '0;
              invincible_n = 1'b0;
            end else begin
              inv_cnt_n = inv_cnt - INV_W'(1);
            end
          end
        end
      end

      DEAD: begin
        lives_n      = '0;
        gameover_n   = 1'b1;
        invincible_n = 1'b0;
      end

      default: begin
        state_n      = IDLE;
        invincible_n = 1'b0;
        inv_cnt_n    = '0;
      end
    endcase
  end

  assign bus.lives         = lives_q;
  assign bus.score         = score_q;
  assign bus.invincible    = invincible_q;
  assign bus.gameover_ctrl = gameover_q;

endmodule

// File: tb/tb_nexys_starship_lives.sv
// tb/tb_nexys_starship_lives.sv - scoreboard bench for the lives/score keeper
module tb_nexys_starship_lives;

  logic Clk;
  logic Reset;

  nexys_starship_lives_if #(.LIVES_W(2), .SCORE_W(14)) bus ();

  nexys_starship_lives #(
    .START_LIVES (3),
    .LIVES_W     (2),
    .INVULN_TICKS(120),
    .INV_W       (7),
    .SCORE_W     (14),
    .SCORE_MAX   (20),
    .KILL_POINTS (1)
  ) dut (
    .Clk  (Clk),
    .Reset(Reset),
    .bus  (bus.slave)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  typedef struct {
    int   idx;
    int   lives;
    int   score;
    logic inv;
    logic go;
  } exp_t;

  exp_t sb[$];
  int   compared   = 0;
  int   mismatched = 0;
  int   step_idx   = 0;

  // Drive one cycle of inputs; the expected registered outputs after that edge go to the scoreboard.
  task automatic step(input logic r, input logic q, input logic h, input logic k,
                      input logic t, input int el, input int es,
                      input logic ei, input logic eg);
    exp_t e;
    @(negedge Clk);
    Reset      = r;
    bus.q_Play = q;
    bus.hit    = h;
    bus.kill   = k;
    bus.tick   = t;
    @(posedge Clk);
    e.idx   = step_idx;
    e.lives = el;
    e.score = es;
    e.inv   = ei;
    e.go    = eg;
    sb.push_back(e);
    step_idx++;
  endtask

  always @(negedge Clk) begin
    if (sb.size() > 0) begin
      exp_t e;
      e = sb.pop_front();
      compared++;
      if (int'(bus.lives) != e.lives || int'(bus.score) != e.score ||
          bus.invincible !== e.inv || bus.gameover_ctrl !== e.go) begin
        mismatched++;
        $display("FAIL step%0d: got lives=%0d score=%0d inv=%0b go=%0b, required lives=%0d score=%0d inv=%0b go=%0b",
                 e.idx, bus.lives, bus.score, bus.invincible, bus.gameover_ctrl,
                 e.lives, e.score, e.inv, e.go);
      end
    end
  end

  initial begin
    Reset      = 1'b0;
    bus.q_Play = 1'b0;
    bus.hit    = 1'b0;
    bus.kill   = 1'b0;
    bus.tick   = 1'b0;

    // Reset, then pulses while idle are ignored
    step(0, 0, 0, 0, 0, 3, 0, 0, 0);
    step(0, 0, 1, 1, 0, 3, 0, 0, 0);
    step(1, 0, 1, 0, 0, 3, 0, 0, 0);
    step(1, 0, 0, 1, 0, 3, 0, 0, 0);
    step(1, 0, 0, 0, 1, 3, 0, 0, 0);

    // Enter play, five kills
    step(1, 1, 0, 0, 0, 3, 0, 0, 0);
    for (int i = 1; i <= 5; i++) step(1, 1, 0, 1, 0, 3, i, 0, 0);

    // First hit, then a hit 10 cycles later is ignored
    step(1, 1, 1, 0, 0, 2, 5, 1, 0);
    for (int i = 0; i < 9; i++) step(1, 1, 0, 0, 0, 2, 5, 1, 0);
    step(1, 1, 1, 0, 0, 2, 5, 1, 0);

    // 120-tick window; a kill on tick 60, a hit on the expiring tick is ignored
    for (int i = 1; i <= 120; i++) begin
      if (i < 60)       step(1, 1, 0, 0, 1, 2, 5, 1, 0);
      else if (i == 60) step(1, 1, 0, 1, 1, 2, 6, 1, 0);
      else if (i < 120) step(1, 1, 0, 0, 1, 2, 6, 1, 0);
      else              step(1, 1, 1, 0, 1, 2, 6, 0, 0);
    end
    step(1, 1, 0, 0, 1, 2, 6, 0, 0);

    // Second hit and its window
    step(1, 1, 1, 0, 0, 1, 6, 1, 0);
    for (int i = 1; i <= 120; i++) step(1, 1, 0, 0, 1, 1, 6, (i < 120) ? 1'b1 : 1'b0, 0);
    step(1, 1, 0, 1, 0, 1, 7, 0, 0);

    // Fatal hit with a simultaneous kill
    step(1, 1, 1, 1, 0, 0, 8, 0, 1);

    // DEAD ignores everything but reset
    step(1, 0, 0, 0, 0, 0, 8, 0, 1);
    step(1, 0, 1, 1, 1, 0, 8, 0, 1);
    step(1, 1, 0, 1, 0, 0, 8, 0, 1);
    step(1, 1, 1, 0, 1, 0, 8, 0, 1);

    // Reset from DEAD
    step(0, 1, 0, 1, 0, 3, 0, 0, 0);
    step(1, 0, 0, 0, 0, 3, 0, 0, 0);

    // Reset mid-window with inv_cnt at 50
    step(1, 1, 0, 0, 0, 3, 0, 0, 0);
    step(1, 1, 1, 0, 0, 2, 0, 1, 0);
    for (int i = 0; i < 70; i++) step(1, 1, 0, 0, 1, 2, 0, 1, 0);
    step(0, 1, 0, 0, 1, 3, 0, 0, 0);

    // Entry edge ignores kill, then saturation at 20
    step(1, 1, 0, 1, 0, 3, 0, 0, 0);
    for (int i = 1; i <= 25; i++) step(1, 1, 0, 1, 0, 3, (i > 20) ? 20 : i, 0, 0);

    // Abnormal play drop from ALIVE holds lives/score
    step(1, 0, 0, 1, 0, 3, 20, 0, 0);
    step(1, 0, 1, 1, 1, 3, 20, 0, 0);
    step(1, 1, 0, 0, 0, 3, 0, 0, 0);

    // Abnormal play drop from INVULN clears invincible
    step(1, 1, 1, 0, 0, 2, 0, 1, 0);
    step(1, 0, 0, 0, 0, 2, 0, 0, 0);
    step(1, 0, 0, 0, 1, 2, 0, 0, 0);
    step(1, 1, 0, 0, 0, 3, 0, 0, 0);
    step(1, 1, 1, 0, 0, 2, 0, 1, 0);

    @(negedge Clk);
    @(negedge Clk);
    if (sb.size() != 0) begin
      mismatched++;
      $display("FAIL drain: %0d entries left, required 0", sb.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
